adc_seq_sched: RTL

Conversion scheduler for the SAR ADC controller. Sequences a programmable list of up to eight channel slots onto one shared SAR conversion engine, triggered by software or an internal periodic timer. Pushes each result into the sample FIFO and reports trigger and FIFO overruns. Sits between the register file (CTRL/SEQCTRL/TCTRL/SOC fields) and the SAR engine/FIFO pair.

---
 rtl/adc_seq_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/adc_seq_sched.sv
// Conversion scheduler: walks up to NSLOT channel slots through one SAR engine and pushes each result to the FIFO.
// Define ADC_SEQ_SCHED_TAG_EN to widen fifo_wdata to {sar_ch, sar_data}; otherwise it carries sar_data only.
module adc_seq_sched #(
    parameter int NSLOT = 8,
    parameter int CHW   = 3,
    parameter int DW    = 10,
    parameter int TW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cont,
    input  logic                  trig_sel,
    input  logic                  sw_soc,
    input  logic [TW-1:0]         timer_period,
    input  logic [2:0]            seq_len,
    input  logic [NSLOT*CHW-1:0]  slot_ch,
    output logic                  sar_soc,
    output logic [CHW-1:0]        sar_ch,
    input  logic                  sar_eoc,
    input  logic [DW-1:0]         sar_data,
    output logic                  fifo_wr,
`ifdef ADC_SEQ_SCHED_TAG_EN
    output logic [DW+CHW-1:0]     fifo_wdata,
`else
    output logic [DW-1:0]         fifo_wdata,
`endif
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  trig_ovr,
    output logic                  fifo_ovr
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_EOC,
        PUSH
    } state_t;

    state_t               state;
    logic [2:0]           idx;
    logic [2:0]           next_idx;
    logic [2:0]           shadow_len;
    logic [2:0]           len_clamped;
    logic [NSLOT*CHW-1:0] shadow_slots;
    logic [TW-1:0]        timer_cnt;
    logic                 tick;
    logic                 trigger;
    logic                 last_slot;

    // >= rather than == so a period shrunk below the running count still wraps promptly.
    assign tick        = en && trig_sel && (timer_cnt >= timer_period);
    assign trigger     = en && (trig_sel ? tick : sw_soc);
    assign next_idx    = idx + 3'd1;
    assign last_slot   = (idx == shadow_len);
    assign len_clamped = (32'(seq_len) > NSLOT - 1) ? 3'(NSLOT - 1) : seq_len;

    always_ff @(posedge clk) begin
        if (rst || !en || !trig_sel) begin
            timer_cnt <= '0;
        end else if (tick) begin
            timer_cnt <= '0;
        end else begin
            timer_cnt <= timer_cnt + TW'(1);
        end
    end

    // fifo_full is sampled together with sar_eoc so the write strobe can be registered into PUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            shadow_len   <= '0;
            shadow_slots <= '0;
            sar_soc      <= 1'b0;
            sar_ch       <= '0;
            fifo_wr      <= 1'b0;
            fifo_wdata   <= '0;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
            trig_ovr     <= 1'b0;
            fifo_ovr     <= 1'b0;
        end else begin
            sar_soc  <= 1'b0;
            fifo_wr  <= 1'b0;
            seq_done <= 1'b0;
            fifo_ovr <= 1'b0;
            trig_ovr <= trigger && (state != IDLE);

            case (state)
                IDLE: begin
                    if (trigger) begin
                        shadow_len   <= len_clamped;
                        shadow_slots <= slot_ch;
                        idx          <= '0;
                        sar_ch       <= slot_ch[CHW-1:0];
                        sar_soc      <= 1'b1;
                        busy         <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    state <= WAIT_EOC;
                end
                WAIT_EOC: begin
                    if (sar_eoc) begin
`ifdef ADC_SEQ_SCHED_TAG_EN
                        fifo_wdata <= {sar_ch, sar_data};
`else
                        fifo_wdata <= sar_data;
`endif
                        fifo_wr  <= !fifo_full;
                        fifo_ovr <= fifo_full;
                        seq_done <= last_slot;
                        state    <= PUSH;
                    end
                end
                PUSH: begin
                    if (last_slot && cont && en) begin
                        shadow_len   <= len_clamped;
                        shadow_slots <= slot_ch;
                        idx          <= '0;
                        sar_ch       <= slot_ch[CHW-1:0];
                        sar_soc      <= 1'b1;
                        state        <= START;
                    end else if (last_slot || !en) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx     <= next_idx;
                        sar_ch  <= shadow_slots[next_idx*CHW +: CHW];
                        sar_soc <= 1'b1;
                        state   <= START;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
